// File: rtl/time_pkg.sv
// time_pkg: shared field indices, FSM states, year limits and calendar helpers
package time_pkg;
  localparam logic [2:0] FLD_YEAR   = 3'd0;
  localparam logic [2:0] FLD_MONTH  = 3'd1;
  localparam logic [2:0] FLD_DAY    = 3'd2;
  localparam logic [2:0] FLD_HOUR   = 3'd3;
  localparam logic [2:0] FLD_MINUTE = 3'd4;
  localparam logic [2:0] FLD_SECOND = 3'd5;

  localparam logic [15:0] YEAR_MIN = 16'd2000;
  localparam logic [15:0] YEAR_MAX = 16'd2099;

  typedef enum logic [1:0] {IDLE, CAPTURE, EDIT, COMMIT} state_t;

  function automatic logic is_leap(input logic [15:0] y);
    return (y % 16'd4 == 16'd0 && y % 16'd100 != 16'd0) || y % 16'd400 == 16'd0;
  endfunction

  function automatic logic [10:0] days_in_month(input logic [15:0] y, input logic [5:0] m);
    return m == 6'd2 ? (is_leap(y) ? 11'd29 : 11'd28) :
           (m == 6'd4 || m == 6'd6 || m == 6'd9 || m == 6'd11) ? 11'd30 : 11'd31;
  endfunction

  // One step up or down inside lo..hi, wrapping at either end
  function automatic logic [15:0] step(input logic [15:0] v, input logic [15:0] lo,
                                       input logic [15:0] hi, input logic up);
    return up ? (v >= hi ? lo : v + 16'd1) : (v <= lo ? hi : v - 16'd1);
  endfunction
endpackage

// File: rtl/weekday_calc.sv
// weekday_calc: Sakamoto day-of-week from year/month/day, 1=Mon..7=Sun
module weekday_calc
  import time_pkg::*;
(
  input  logic [15:0] year,
  input  logic [5:0]  month,
  input  logic [10:0] day,
  output logic [10:0] week
);
  logic [15:0] y, t, s, w;

  // Month offset table; January and February count as part of the previous year
  always_comb begin
    case (month)
      6'd2:    t = 16'd3;
      6'd3:    t = 16'd2;
      6'd4:    t = 16'd5;
      6'd6:    t = 16'd3;
      6'd7:    t = 16'd5;
      6'd8:    t = 16'd1;
      6'd9:    t = 16'd4;
      6'd10:   t = 16'd6;
      6'd11:   t = 16'd2;
      6'd12:   t = 16'd4;
      default: t = 16'd0;
    endcase
  end

  // Sakamoto sum gives 0=Sun; Sunday is moved to 7
  always_comb begin
    y = month < 6'd3 ? year - 16'd1 : year;
    s = y + y / 16'd4 - y / 16'd100 + y / 16'd400 + t + {5'd0, day};
    w = s % 16'd7;
    week = w == 16'd0 ? 11'd7 : w[10:0];
  end
endmodule

// File: rtl/time_set_ctrl.sv
// time_set_ctrl: capture, field-by-field edit and one-cycle load of date/time (idle abort under TIME_SET_TIMEOUT_EN)
module time_set_ctrl
  import time_pkg::*;
  #(parameter int unsigned TIMEOUT_CYCLES = 600_000_000)
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        btn_mode,
  input  logic        btn_next,
  input  logic        btn_up,
  input  logic        btn_down,
  input  logic [15:0] cur_year,
  input  logic [5:0]  cur_month,
  input  logic [10:0] cur_day,
  input  logic [10:0] cur_hour,
  input  logic [10:0] cur_minute,
  input  logic [10:0] cur_second,
  output logic [15:0] set_year,
  output logic [5:0]  set_month,
  output logic [10:0] set_day,
  output logic [10:0] set_hour,
  output logic [10:0] set_minute,
  output logic [10:0] set_second,
  output logic [10:0] set_week,
  output logic        load,
  output logic        editing,
  output logic [2:0]  sel_field
);
  state_t state, nxt;
  logic timeout;
  logic any_btn;
  logic [15:0] c_year, n_year;
  logic [5:0]  c_month, n_month;
  logic [10:0] c_dim, c_day, c_hour, c_minute, c_second;
  logic [10:0] n_dim, n_day, n_hour, n_minute, n_second;

  assign any_btn = btn_mode | btn_next | btn_up | btn_down;

`ifdef TIME_SET_TIMEOUT_EN
  logic [31:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt <= '0;
    else cnt <= (state != EDIT || any_btn) ? '0 : cnt + 32'd1;
  end

  assign timeout = cnt == 32'(TIMEOUT_CYCLES - 1) && !any_btn;
`else
  assign timeout = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else state <= nxt;
  end

  always_comb begin
    nxt = state;
    case (state)
      IDLE:    nxt = btn_mode ? CAPTURE : IDLE;
      CAPTURE: nxt = EDIT;
      EDIT:    nxt = btn_mode ? COMMIT : timeout ? IDLE : EDIT;
      default: nxt = IDLE;
    endcase
  end

  always_comb begin
    load = state == COMMIT;
    editing = state == CAPTURE || state == EDIT;
  end

  always_comb begin
    c_year = (cur_year < YEAR_MIN || cur_year > YEAR_MAX) ? YEAR_MIN : cur_year;
    c_month = (cur_month == 6'd0 || cur_month > 6'd12) ? 6'd1 : cur_month;
    c_dim = days_in_month(c_year, c_month);
    c_day = cur_day == 11'd0 ? 11'd1 : cur_day > c_dim ? c_dim : cur_day;
    c_hour = cur_hour > 11'd23 ? 11'd0 : cur_hour;
    c_minute = cur_minute > 11'd59 ? 11'd0 : cur_minute;
    c_second = cur_second > 11'd59 ? 11'd0 : cur_second;
  end

  always_comb begin
    n_year = sel_field == FLD_YEAR ? step(set_year, YEAR_MIN, YEAR_MAX, btn_up) : set_year;
    n_month = sel_field == FLD_MONTH ? 6'(step(16'(set_month), 16'd1, 16'd12, btn_up)) : set_month;
    n_dim = days_in_month(n_year, n_month);
    n_day = sel_field == FLD_DAY ? 11'(step(16'(set_day), 16'd1, 16'(n_dim), btn_up)) :
            set_day > n_dim ? n_dim : set_day;
    n_hour = sel_field == FLD_HOUR ? 11'(step(16'(set_hour), 16'd0, 16'd23, btn_up)) : set_hour;
    n_minute = sel_field == FLD_MINUTE ? 11'(step(16'(set_minute), 16'd0, 16'd59, btn_up)) : set_minute;
    n_second = sel_field == FLD_SECOND ? 11'(step(16'(set_second), 16'd0, 16'd59, btn_up)) : set_second;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      set_year <= YEAR_MIN;
      set_month <= 6'd1;
      set_day <= 11'd1;
      set_hour <= '0;
      set_minute <= '0;
      set_second <= '0;
      sel_field <= FLD_YEAR;
    end else if (state == CAPTURE) begin
      set_year <= c_year;
      set_month <= c_month;
      set_day <= c_day;
      set_hour <= c_hour;
      set_minute <= c_minute;
      set_second <= c_second;
      sel_field <= FLD_YEAR;
    end else if (state == EDIT && !btn_mode) begin
      if (btn_next) sel_field <= sel_field == FLD_SECOND ? FLD_YEAR : sel_field + 3'd1;
      else if (btn_up || btn_down) begin
        set_year <= n_year;
        set_month <= n_month;
        set_day <= n_day;
        set_hour <= n_hour;
        set_minute <= n_minute;
        set_second <= n_second;
      end
    end
  end

  weekday_calc u_week (
    .year(set_year),
    .month(set_month),
    .day(set_day),
    .week(set_week)
  );
endmodule

// File: tb/tb_time_set_ctrl.sv
// tb_time_set_ctrl: directed checks of capture, editing, commit, reset and timeout behaviour
module tb_time_set_ctrl;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic btn_mode = 1'b0, btn_next = 1'b0, btn_up = 1'b0, btn_down = 1'b0;
  logic [15:0] cur_year = '0;
  logic [5:0]  cur_month = '0;
  logic [10:0] cur_day = '0, cur_hour = '0, cur_minute = '0, cur_second = '0;
  logic [15:0] set_year;
  logic [5:0]  set_month;
  logic [10:0] set_day, set_hour, set_minute, set_second, set_week;
  logic load, editing;
  logic [2:0] sel_field;
  int tests = 0, fails = 0;
  int load_cnt = 0;

  always #5 clk = ~clk;

  always @(posedge clk) if (load) load_cnt <= load_cnt + 1;

  time_set_ctrl #(.TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .btn_mode(btn_mode), .btn_next(btn_next), .btn_up(btn_up), .btn_down(btn_down),
    .cur_year(cur_year), .cur_month(cur_month), .cur_day(cur_day),
    .cur_hour(cur_hour), .cur_minute(cur_minute), .cur_second(cur_second),
    .set_year(set_year), .set_month(set_month), .set_day(set_day),
    .set_hour(set_hour), .set_minute(set_minute), .set_second(set_second),
    .set_week(set_week), .load(load), .editing(editing), .sel_field(sel_field)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic check_dt(input string tag, input int y, input int mo, input int d,
                          input int h, input int mi, input int s);
    check({tag, ".year"}, 32'(set_year), y);
    check({tag, ".month"}, 32'(set_month), mo);
    check({tag, ".day"}, 32'(set_day), d);
    check({tag, ".hour"}, 32'(set_hour), h);
    check({tag, ".minute"}, 32'(set_minute), mi);
    check({tag, ".second"}, 32'(set_second), s);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic press(input logic [3:0] b);
    {btn_mode, btn_next, btn_up, btn_down} = b;
    tick();
    {btn_mode, btn_next, btn_up, btn_down} = 4'b0000;
  endtask

  task automatic capture(input int y, input int mo, input int d, input int h, input int mi, input int s);
    cur_year = 16'(y); cur_month = 6'(mo); cur_day = 11'(d);
    cur_hour = 11'(h); cur_minute = 11'(mi); cur_second = 11'(s);
    press(4'b1000);
    tick();
  endtask

  task automatic nexts(input int n);
    for (int i = 0; i < n; i++) press(4'b0100);
  endtask

  task automatic commit();
    press(4'b1000);
    tick();
  endtask

  initial begin
    tick(); tick();
    check_dt("rst", 2000, 1, 1, 0, 0, 0);
    check("rst.week", 32'(set_week), 6);
    check("rst.load", 32'(load), 0);
    check("rst.editing", 32'(editing), 0);
    check("rst.sel", 32'(sel_field), 0);
    rst_n = 1'b1;
    tick();

    capture(2023, 5, 9, 14, 30, 59);
    check("cap1.editing", 32'(editing), 1);
    check_dt("cap1", 2023, 5, 9, 14, 30, 59);
    check("cap1.week", 32'(set_week), 2);
    check("cap1.sel", 32'(sel_field), 0);
    nexts(5);
    check("sel5", 32'(sel_field), 5);
    press(4'b0010);
    check("sec_wrap", 32'(set_second), 0);
    check("sec_wrap.min", 32'(set_minute), 30);
    nexts(1);
    check("sel_wrap", 32'(sel_field), 0);
    press(4'b0110);
    check("next_over_up.sel", 32'(sel_field), 1);
    check("next_over_up.year", 32'(set_year), 2023);
    nexts(5);
    press(4'b1010);
    check("commit.load", 32'(load), 1);
    check("commit.editing", 32'(editing), 0);
    check("commit.year", 32'(set_year), 2023);
    tick();
    check("post.load", 32'(load), 0);
    check("post.editing", 32'(editing), 0);
    check("load_once", load_cnt, 1);
    check_dt("held", 2023, 5, 9, 14, 30, 0);
    press(4'b0110);
    check("idle_ign.sel", 32'(sel_field), 0);
    check("idle_ign.year", 32'(set_year), 2023);
    check("idle_ign.editing", 32'(editing), 0);

    capture(2024, 3, 31, 12, 0, 0);
    nexts(1);
    press(4'b0001);
    check_dt("feb_leap", 2024, 2, 29, 12, 0, 0);
    check("feb_leap.week", 32'(set_week), 4);
    nexts(5);
    press(4'b0010);
    check_dt("feb_clamp", 2025, 2, 28, 12, 0, 0);
    check("feb_clamp.week", 32'(set_week), 5);
    nexts(2);
    press(4'b0010);
    check("day_wrap_up", 32'(set_day), 1);
    press(4'b0001);
    check("day_wrap_dn", 32'(set_day), 28);
    commit();

    capture(2099, 6, 15, 8, 0, 0);
    press(4'b0010);
    check("year_wrap", 32'(set_year), 2000);
    check("year_wrap.day", 32'(set_day), 15);
    press(4'b0001);
    check("year_wrap_dn", 32'(set_year), 2099);
    commit();

    capture(1999, 13, 0, 25, 60, 60);
    check_dt("clamp", 2000, 1, 1, 0, 0, 0);
    nexts(3);
    press(4'b0001);
    check("hour_wrap", 32'(set_hour), 23);
    press(4'b0010);
    check("hour_wrap_up", 32'(set_hour), 0);
    commit();

    capture(2000, 2, 30, 1, 2, 3);
    check_dt("gregorian", 2000, 2, 29, 1, 2, 3);
    check("gregorian.week", 32'(set_week), 2);
    commit();

    load_cnt = 0;
    capture(2023, 5, 9, 14, 30, 59);
    press(4'b0010);
    check("pre_rst.year", 32'(set_year), 2024);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst.year", 32'(set_year), 2000);
    check("async_rst.editing", 32'(editing), 0);
    check("async_rst.sel", 32'(sel_field), 0);
    tick();
    check("async_rst.load", 32'(load), 0);
    rst_n = 1'b1;
    tick(); tick();
    check("rst_no_load", load_cnt, 0);

`ifdef TIME_SET_TIMEOUT_EN
    capture(2023, 5, 9, 14, 30, 59);
    nexts(2);
    for (int i = 0; i < 15; i++) tick();
    check("to.before", 32'(editing), 1);
    tick();
    check("to.expired", 32'(editing), 0);
    check("to.kept", 32'(sel_field), 2);
    capture(2023, 5, 9, 14, 30, 59);
    for (int i = 0; i < 14; i++) tick();
    press(4'b0100);
    for (int i = 0; i < 15; i++) tick();
    check("to.restart", 32'(editing), 1);
    tick();
    check("to.restart_exp", 32'(editing), 0);
    check("to.no_load", load_cnt, 0);
`else
    capture(2023, 5, 9, 14, 30, 59);
    for (int i = 0; i < 40; i++) tick();
    check("persist.editing", 32'(editing), 1);
    commit();
    check("persist.load", load_cnt, 1);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
